// File: rtl/autosa_glb_csb_master.sv
// CSB initiator for the GLB register slave: range-checks each word-addressed
// request, drives one register access and returns read data or a write ack.
module autosa_glb_csb_master #(
    parameter int unsigned       ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       RANGE_WORDS = 1024
) (
    input  logic              autosa_core_clk,
    input  logic              autosa_core_rst,
    input  logic              csb_req_valid,
    output logic              csb_req_ready,
    input  logic [ADDR_W-1:0] csb_req_addr,
    input  logic [31:0]       csb_req_wdat,
    input  logic              csb_req_write,
    input  logic              csb_req_nposted,
    output logic              csb_resp_valid,
    input  logic              csb_resp_ready,
    output logic [31:0]       csb_resp_rdat,
    output logic              csb_resp_is_write,
    output logic              csb_resp_error,
    output logic [11:0]       reg_offset,
    output logic [31:0]       reg_wr_data,
    output logic              reg_wr_en,
    input  logic [31:0]       reg_rd_data
);

    // Window size widened by one bit so RANGE_WORDS itself is representable.
    localparam logic [ADDR_W:0] RANGE_LIM = (ADDR_W + 1)'(RANGE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic              nposted_q, nposted_d;
    logic              hit_q, hit_d;
    logic [11:0]       reg_offset_q, reg_offset_d;
    logic [31:0]       reg_wr_data_q, reg_wr_data_d;
    logic              reg_wr_en_q, reg_wr_en_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdat_q, resp_rdat_d;
    logic              resp_is_write_q, resp_is_write_d;
    logic              resp_error_q, resp_error_d;

    logic              accept;
    logic              posted_write_q;
    logic [ADDR_W-1:0] addr_diff;
    logic              req_hit;

    // Unsigned window check; the subtraction result is only trusted when addr >= base.
    assign addr_diff      = csb_req_addr - BASE_ADDR;
    assign req_hit        = (csb_req_addr >= BASE_ADDR) && ({1'b0, addr_diff} < RANGE_LIM);
    assign accept         = csb_req_valid && csb_req_ready;
    assign posted_write_q = write_q && !nposted_q;

    // State register.
    always_ff @(posedge autosa_core_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (autosa_core_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one ACCESS cycle, then a response unless the write is posted.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_ACCESS;
            ST_ACCESS: state_d = posted_write_q ? ST_IDLE : ST_RESP;
            ST_RESP:   if (csb_resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode: requests are only taken in IDLE and never while reset is held.
    always_comb begin
        csb_req_ready = (state_q == ST_IDLE) && !autosa_core_rst;
    end

    // Datapath: capture the request on accept, build the response at the end of ACCESS.
    always_comb begin
        write_d         = write_q;
        nposted_d       = nposted_q;
        hit_d           = hit_q;
        reg_offset_d    = reg_offset_q;
        reg_wr_data_d   = reg_wr_data_q;
        reg_wr_en_d     = 1'b0;
        resp_valid_d    = resp_valid_q;
        resp_rdat_d     = resp_rdat_q;
        resp_is_write_d = resp_is_write_q;
        resp_error_d    = resp_error_q;

        if (accept) begin
            write_d     = csb_req_write;
            nposted_d   = csb_req_nposted;
            hit_d       = req_hit;
            reg_wr_en_d = csb_req_write && req_hit;
            if (req_hit) begin
                reg_offset_d = {addr_diff[9:0], 2'b00};
            end
            if (csb_req_write && req_hit) begin
                reg_wr_data_d = csb_req_wdat;
            end
        end

        if ((state_q == ST_ACCESS) && !posted_write_q) begin
            resp_valid_d    = 1'b1;
            resp_rdat_d     = (!write_q && hit_q) ? reg_rd_data : 32'h0;
            resp_is_write_d = write_q;
            resp_error_d    = !hit_q;
        end

        if ((state_q == ST_RESP) && csb_resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge autosa_core_clk) begin
        // NOTE: every datapath flop is reset so a mid-transaction reset leaves no stale strobe or response.
        if (autosa_core_rst) begin
            write_q         <= 1'b0;
            nposted_q       <= 1'b0;
            hit_q           <= 1'b0;
            reg_offset_q    <= 12'h0;
            reg_wr_data_q   <= 32'h0;
            reg_wr_en_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rdat_q     <= 32'h0;
            resp_is_write_q <= 1'b0;
            resp_error_q    <= 1'b0;
        end else begin
            write_q         <= write_d;
            nposted_q       <= nposted_d;
            hit_q           <= hit_d;
            reg_offset_q    <= reg_offset_d;
            reg_wr_data_q   <= reg_wr_data_d;
            reg_wr_en_q     <= reg_wr_en_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdat_q     <= resp_rdat_d;
            resp_is_write_q <= resp_is_write_d;
            resp_error_q    <= resp_error_d;
        end
    end

    assign reg_offset        = reg_offset_q;
    assign reg_wr_data       = reg_wr_data_q;
    assign reg_wr_en         = reg_wr_en_q;
    assign csb_resp_valid    = resp_valid_q;
    assign csb_resp_rdat     = resp_rdat_q;
    assign csb_resp_is_write = resp_is_write_q;
    assign csb_resp_error    = resp_error_q;

endmodule

// File: tb/tb_autosa_glb_csb_master.sv
// Self-checking bench for autosa_glb_csb_master: directed steps followed by
// randomized requests, checked against a word-array model of the GLB window.
module tb_autosa_glb_csb_master;

    localparam int ADDR_W = 16;
    localparam int BASE   = 'h0100;
    localparam int RANGE  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [31:0] req_wdat;
    logic        req_write;
    logic        req_nposted;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdat;
    logic        resp_is_write;
    logic        resp_error;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic [31:0] reg_rd_data;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    autosa_glb_csb_master #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (16'(BASE)),
        .RANGE_WORDS (RANGE)
    ) dut (
        .autosa_core_clk   (clk),
        .autosa_core_rst   (rst),
        .csb_req_valid     (req_valid),
        .csb_req_ready     (req_ready),
        .csb_req_addr      (req_addr),
        .csb_req_wdat      (req_wdat),
        .csb_req_write     (req_write),
        .csb_req_nposted   (req_nposted),
        .csb_resp_valid    (resp_valid),
        .csb_resp_ready    (resp_ready),
        .csb_resp_rdat     (resp_rdat),
        .csb_resp_is_write (resp_is_write),
        .csb_resp_error    (resp_error),
        .reg_offset        (reg_offset),
        .reg_wr_data       (reg_wr_data),
        .reg_wr_en         (reg_wr_en),
        .reg_rd_data       (reg_rd_data)
    );

    // Register slave: 1024 words, combinational read, write on the strobe.
    logic [31:0] slave_mem [1024];
    logic        slave_init;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h00303031;
        return 32'hA5000000 ^ (32'(i) * 32'h00010003);
    endfunction

    always @(posedge clk) begin
        if (slave_init) begin
            for (int i = 0; i < 1024; i++) slave_mem[i] <= init_word(i);
        end else if (reg_wr_en) begin
            slave_mem[reg_offset[11:2]] <= reg_wr_data;
        end
    end

    assign reg_rd_data = slave_mem[reg_offset[11:2]];

    // Reference model: window contents indexed by word offset, plus the last driven offset/data.
    logic [31:0] ref_mem [1024];
    logic [11:0] exp_offset;
    logic [31:0] exp_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request end to end; stall = cycles resp_ready is held low after the response appears.
    task automatic do_req(input int addr, input bit wr, input bit np, input logic [31:0] wdat,
                          input int stall, input bit keep_valid, input int exp_wait);
        int          waited;
        int          idx;
        bit          hit;
        bit          has_resp;
        logic [31:0] exp_rdat;

        hit      = (addr >= BASE) && (addr - BASE < RANGE);
        idx      = hit ? addr - BASE : 0;
        has_resp = !wr || np;

        req_valid   = 1'b1;
        req_addr    = 16'(addr);
        req_wdat    = wdat;
        req_write   = wr;
        req_nposted = np;
        waited      = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_timeout", 32'(waited < 20), 32'd1);
        if (exp_wait >= 0) check("accept_wait", 32'(waited), 32'(exp_wait));

        tick();
        if (!keep_valid) req_valid = 1'b0;
        resp_ready = 1'b0;

        exp_rdat = (!wr && hit) ? ref_mem[idx] : 32'h0;
        if (hit) exp_offset = 12'(idx * 4);
        if (wr && hit) begin
            exp_wdata    = wdat;
            ref_mem[idx] = wdat;
        end

        check("c1_wr_en", reg_wr_en, 32'(wr && hit));
        check("c1_offset", reg_offset, exp_offset);
        check("c1_wr_data", reg_wr_data, exp_wdata);
        check("c1_req_ready", req_ready, 32'd0);
        check("c1_resp_valid", resp_valid, 32'd0);

        tick();
        check("c2_wr_en", reg_wr_en, 32'd0);
        check("c2_offset", reg_offset, exp_offset);
        if (has_resp) begin
            check("c2_resp_valid", resp_valid, 32'd1);
            check("c2_rdat", resp_rdat, exp_rdat);
            check("c2_is_write", resp_is_write, 32'(wr));
            check("c2_error", resp_error, 32'(!hit));
            check("c2_req_ready", req_ready, 32'd0);
            for (int i = 0; i < stall; i++) begin
                tick();
                check("stall_resp_valid", resp_valid, 32'd1);
                check("stall_rdat", resp_rdat, exp_rdat);
                check("stall_is_write", resp_is_write, 32'(wr));
                check("stall_error", resp_error, 32'(!hit));
                check("stall_req_ready", req_ready, 32'd0);
                check("stall_wr_en", reg_wr_en, 32'd0);
            end
            resp_ready = 1'b1;
            tick();
            check("hs_resp_valid", resp_valid, 32'd0);
            check("hs_req_ready", req_ready, 32'd1);
        end else begin
            check("pw_resp_valid", resp_valid, 32'd0);
            check("pw_req_ready", req_ready, 32'd1);
        end
    endtask

    // Global time limit so a stuck design can never hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        slave_init  = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_wdat    = '0;
        req_write   = 1'b0;
        req_nposted = 1'b0;
        resp_ready  = 1'b0;
        exp_offset  = 12'h0;
        exp_wdata   = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        // Reset state.
        tick();
        tick();
        slave_init = 1'b0;
        check("rst_req_ready", req_ready, 32'd0);
        check("rst_resp_valid", resp_valid, 32'd0);
        check("rst_wr_en", reg_wr_en, 32'd0);
        check("rst_offset", reg_offset, 32'd0);
        check("rst_wr_data", reg_wr_data, 32'd0);
        check("rst_rdat", resp_rdat, 32'd0);
        check("rst_is_write", resp_is_write, 32'd0);
        check("rst_error", resp_error, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_req_ready", req_ready, 32'd1);

        // Posted write, read, non-posted write.
        do_req(BASE + 1, 1'b1, 1'b0, 32'h003F00FF, 0, 1'b0, 0);
        check("t1_offset", reg_offset, 32'h004);
        do_req(BASE + 0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 0);
        do_req(BASE + 3, 1'b1, 1'b1, 32'h1, 0, 1'b0, 0);
        check("t3_offset", reg_offset, 32'h00C);

        // Window boundaries: first miss above, last hit, miss just below base.
        do_req(BASE + 1024, 1'b0, 1'b0, 32'h0, 0, 1'b0, 0);
        do_req(BASE + 1023, 1'b0, 1'b0, 32'h0, 0, 1'b0, 0);
        do_req(BASE - 1, 1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0, 0);
        check("t4_offset_kept", reg_offset, 32'hFFC);

        // Response back-pressure with the next request already waiting.
        do_req(BASE + 1, 1'b0, 1'b0, 32'h0, 5, 1'b1, 0);
        do_req(BASE + 1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 0);

        // Reset during ACCESS of a non-posted write whose strobe is already out.
        req_valid   = 1'b1;
        req_addr    = 16'(BASE + 5);
        req_wdat    = 32'hCAFE0005;
        req_write   = 1'b1;
        req_nposted = 1'b1;
        check("t6_ready", req_ready, 32'd1);
        tick();
        req_valid = 1'b0;
        check("t6_strobe", reg_wr_en, 32'd1);
        ref_mem[5] = 32'hCAFE0005;
        rst        = 1'b1;
        tick();
        exp_offset = 12'h0;
        exp_wdata  = 32'h0;
        check("t6_req_ready", req_ready, 32'd0);
        check("t6_resp_valid", resp_valid, 32'd0);
        check("t6_wr_en", reg_wr_en, 32'd0);
        check("t6_offset", reg_offset, 32'd0);
        check("t6_wr_data", reg_wr_data, 32'd0);
        check("t6_rdat", resp_rdat, 32'd0);
        check("t6_is_write", resp_is_write, 32'd0);
        check("t6_error", resp_error, 32'd0);
        rst = 1'b0;
        tick();
        check("t6_idle_ready", req_ready, 32'd1);
        tick();
        check("t6_no_resp", resp_valid, 32'd0);
        do_req(BASE + 5, 1'b0, 1'b0, 32'h0, 0, 1'b0, 0);

        // Randomized traffic: hits on a small hot set, boundaries, and misses on both sides.
        for (int t = 0; t < 60; t++) begin
            int a;
            int kind;
            bit wr;
            bit np;
            int stall;
            kind = int'($urandom_range(0, 4));
            case (kind)
                0:       a = BASE + int'($urandom_range(0, RANGE - 1));
                1:       a = BASE + RANGE - 1 + int'($urandom_range(0, 1));
                2:       a = int'($urandom_range(0, BASE - 1));
                3:       a = int'($urandom_range(BASE + RANGE, 65535));
                default: a = BASE + int'($urandom_range(0, 7));
            endcase
            wr    = 1'($urandom_range(0, 1));
            np    = 1'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 2));
            do_req(a, wr, np, $urandom, stall, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
